adder_accumulator: RTL
======================

ADDER_ACCUMULATOR -- requirements
Module: adder_accumulator

Interface
REQ-001 SHALL have parameter Width, default 32, meaning operand and sum width in bits.
REQ-002 SHALL have parameter CountWidth, default 8, meaning width of the operand and carry counters.
REQ-003 SHALL have port Clock  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port Reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port InValid  input  1  upstream operand valid.
REQ-006 SHALL have port InReady  output  1  block can accept an operand this cycle.
REQ-007 SHALL have port InData  input  Width  operand to accumulate.
REQ-008 SHALL have port InLast  input  1  marks final operand of a packet; qualified by InValid.
REQ-009 SHALL have port OutValid  output  1  packet result available.
REQ-010 SHALL have port OutReady  input  1  downstream accepts result.
REQ-011 SHALL have port OutSum  output  Width  modulo-2^Width sum of packet operands.
REQ-012 SHALL have port OutCarries  output  CountWidth  number of carry-outs generated during the packet, saturating.
REQ-013 SHALL have port OutCount  output  CountWidth  number of operands in the packet, saturating.

Function
REQ-014 SHALL implement a two-state machine: ACCUM (InReady=1, OutValid=0) and DONE (InReady=0, OutValid=1).
REQ-015 SHALL accept an operand only on a cycle where InValid=1 and InReady=1 (input beat).
REQ-016 SHALL, on each input beat, update Sum <= Sum + InData (Width-bit add), discarding bit Width of the result from Sum.
REQ-017 SHALL, on each input beat whose add produces carry-out 1, increment the carry counter, saturating at 2^CountWidth-1.
REQ-018 SHALL, on each input beat, increment the operand counter, saturating at 2^CountWidth-1.
REQ-019 SHALL, on an input beat with InLast=1, transition ACCUM->DONE; OutValid rises the cycle after that beat (latency 1 cycle from last beat).
REQ-020 SHALL hold OutSum, OutCarries, OutCount stable throughout DONE until the output handshake.
REQ-021 SHALL complete the output handshake on a cycle with OutValid=1 and OutReady=1, then transition DONE->ACCUM and clear Sum, carry counter and operand counter to 0.
REQ-022 SHALL ignore InValid, InData and InLast while in DONE (no beat, no state change).
REQ-023 SHALL NOT accept an input beat in the same cycle as the output handshake; first beat of the next packet is accepted no earlier than the cycle after.
REQ-024 SHALL treat a packet of a single operand (InLast=1 on first beat) as valid: OutSum=InData, OutCarries=0, OutCount=1.
REQ-025 SHALL drive OutSum, OutCarries, OutCount with the running accumulator values in ACCUM; these are only meaningful while OutValid=1.
REQ-026 SHALL derive InReady and OutValid directly from state (registered, no combinational path from InValid or OutReady).

Reset
REQ-027 SHALL, while Reset_n=0, force state to ACCUM, Sum=0, carry counter=0, operand counter=0, hence InReady=1, OutValid=0, OutSum=0, OutCarries=0, OutCount=0.
REQ-028 SHALL, on reset asserted mid-packet or in DONE, discard the partial or pending result without producing an output handshake.
REQ-029 SHALL resume normal operation on the first rising Clock edge after Reset_n deasserts.

Verification
REQ-030 SHALL cover: packet 1,2,3 (InLast on 3), OutReady=1 -> OutValid one cycle after last beat, OutSum=6, OutCarries=0, OutCount=3.
REQ-031 SHALL cover: packet 0xFFFFFFFF, 0x00000002, 0xFFFFFFFF (InLast) -> OutSum=0x00000000, OutCarries=2, OutCount=3.
REQ-032 SHALL cover: single beat 0x12345678 with InLast, OutReady held 0 for 5 cycles -> OutValid high and outputs stable for all 5, InReady=0, InValid pulses ignored; handshake then InReady=1 next cycle with counters 0.
REQ-033 SHALL cover: 300 beats of 0xFFFFFFFF (InLast on last), Width=32, CountWidth=8 -> OutCount=255, OutCarries=255, OutSum=0xFFFFFED4 (300*0xFFFFFFFF mod 2^32).
REQ-034 SHALL cover: Reset_n pulsed low after 2 beats of a packet -> all outputs 0, OutValid=0; next packet 5,7 (InLast) -> OutSum=12, OutCount=2.
REQ-035 SHALL cover: InValid held 1 continuously across two packets 4,InLast 9 -> first result OutSum=4, OutCount=1, second OutSum=9, OutCount=1; operand 9 accepted only after first handshake.

Source files
------------

// File: rtl/adder_accumulator.sv
// adder_accumulator: packet accumulator with valid/ready handshakes on both sides.
// Operands are summed modulo 2^Width. A saturating count of carry-outs and a
// saturating count of operands are kept alongside the sum. The result is offered
// downstream once the packet's final operand has been taken. The accumulator
// clears when the downstream side accepts that result.
module adder_accumulator #(
    parameter int Width      = 32,
    parameter int CountWidth = 8
) (
    input  logic                  Clock,
    input  logic                  Reset_n,
    input  logic                  InValid,
    output logic                  InReady,
    input  logic [Width-1:0]      InData,
    input  logic                  InLast,
    output logic                  OutValid,
    input  logic                  OutReady,
    output logic [Width-1:0]      OutSum,
    output logic [CountWidth-1:0] OutCarries,
    output logic [CountWidth-1:0] OutCount
);

    // Two states. ACCUM takes operands. DONE presents the result.
    localparam logic [0:0] ACCUM = 1'b0;
    localparam logic [0:0] DONE  = 1'b1;

    localparam logic [CountWidth-1:0] CountMax = '1;
    localparam logic [CountWidth-1:0] CountOne = {{(CountWidth-1){1'b0}}, 1'b1};

    logic [0:0]            state_q;
    logic [0:0]            state_next;
    logic [Width-1:0]      sum_q;
    logic [Width-1:0]      sum_next;
    logic [CountWidth-1:0] carries_q;
    logic [CountWidth-1:0] carries_next;
    logic [CountWidth-1:0] count_q;
    logic [CountWidth-1:0] count_next;

    logic                  in_beat;
    logic                  out_handshake;
    logic [Width:0]        add_full;
    logic                  add_carry;

    // The handshakes are qualified by the registered state only. Because of this,
    // InReady and OutValid never depend combinationally on InValid or OutReady.
    // An input beat cannot coincide with the output handshake, since each one
    // needs a different state.
    assign in_beat       = InValid  && (state_q == ACCUM);
    assign out_handshake = OutReady && (state_q == DONE);

    // The add is one bit wider than the operands. Its top bit is the carry-out.
    // The top bit is dropped from the stored sum.
    assign add_full  = {1'b0, sum_q} + {1'b0, InData};
    assign add_carry = add_full[Width];

    // Next-state and next-accumulator selection
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves
        // a value unassigned and no latch is inferred.
        state_next   = state_q;
        sum_next     = sum_q;
        carries_next = carries_q;
        count_next   = count_q;

        case (state_q)
            ACCUM: begin
                if (in_beat) begin
                    sum_next = add_full[Width-1:0];
                    if (add_carry && (carries_q != CountMax)) begin
                        carries_next = carries_q + CountOne;
                    end
                    if (count_q != CountMax) begin
                        count_next = count_q + CountOne;
                    end
                    if (InLast) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                // The inputs are ignored here. The result stays frozen until the
                // downstream side takes it.
                if (out_handshake) begin
                    state_next   = ACCUM;
                    sum_next     = '0;
                    carries_next = '0;
                    count_next   = '0;
                end
            end
            default: begin
                state_next = ACCUM;
            end
        endcase
    end

    // State and accumulator registers. Asynchronous reset discards any partial
    // or pending packet.
    always_ff @(posedge Clock or negedge Reset_n) begin
        // NOTE: sequential state uses non-blocking assignments, so every register
        // samples the values from before the edge.
        if (!Reset_n) begin
            state_q   <= ACCUM;
            sum_q     <= '0;
            carries_q <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_next;
            sum_q     <= sum_next;
            carries_q <= carries_next;
            count_q   <= count_next;
        end
    end

    // Handshake flags come straight from state. The result outputs show the
    // running accumulator.
    assign InReady    = (state_q == ACCUM);
    assign OutValid   = (state_q == DONE);
    assign OutSum     = sum_q;
    assign OutCarries = carries_q;
    assign OutCount   = count_q;

endmodule
